reqack_word_packer: RTL and testbench

//  Consumer-side partner of the REQ/ACK buffered FIFO: drains narrow words from a FIFO

---
 rtl/reqack_word_packer.sv | 149 ++++++++++++++
 tb/tb_reqack_word_packer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reqack_word_packer.sv
// ---------------------------------------------------------------------------
// reqack_word_packer
//
// Drains narrow words from a REQ/ACK FIFO output port and packs PACKRATIO of
// them into one wide word on its own REQ/ACK output port. The first word of a
// packet goes to the least significant slice. FlushREQ emits a partially
// filled word, zero-padded, together with its valid-word count.
//
// Ports
//   clk          in   clock, all state on rising edge
//   async_rst_n  in   asynchronous reset, active low
//   clk_en       in   state advances only when high; REQ/ACK outputs gated
//   sync_rst     in   synchronous reset, active high, honoured regardless of clk_en
//   InputREQ     in   source has a word
//   InputACK     out  packer accepts a word this cycle
//   InputData    in   narrow word
//   FlushREQ     in   emit the partial word now
//   OutputREQ    out  packed word valid
//   OutputACK    in   sink takes the packed word
//   OutputData   out  packed word (NARROWBITWIDTH*PACKRATIO bits)
//   OutputCount  out  number of valid narrow words in OutputData
// ---------------------------------------------------------------------------
module reqack_word_packer #(
  parameter int NARROWBITWIDTH = 16,
  parameter int PACKRATIO      = 2,
  parameter int COUNTBITWIDTH  = $clog2(PACKRATIO + 1)
) (
  input  logic                                clk,
  input  logic                                async_rst_n,
  input  logic                                clk_en,
  input  logic                                sync_rst,
  input  logic                                InputREQ,
  output logic                                InputACK,
  input  logic [NARROWBITWIDTH-1:0]           InputData,
  input  logic                                FlushREQ,
  output logic                                OutputREQ,
  input  logic                                OutputACK,
  output logic [NARROWBITWIDTH*PACKRATIO-1:0] OutputData,
  output logic [COUNTBITWIDTH-1:0]            OutputCount
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packerState;

  packerState               stateReg;
  packerState               stateNext;
  logic [COUNTBITWIDTH-1:0] countReg;
  logic [COUNTBITWIDTH-1:0] countNext;
  logic [COUNTBITWIDTH-1:0] countInc;

  // Buffer control shared by all slices: bufLoad writes InputData into slice
  // bufLoadIdx, bufClear zeroes every other slice (the outgoing word leaves).
  logic                     bufLoad;
  logic                     bufClear;
  logic [COUNTBITWIDTH-1:0] bufLoadIdx;

  assign countInc = countReg + COUNTBITWIDTH'(1);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      stateReg <= FILL;
      countReg <= '0;
    end else if (sync_rst) begin
      stateReg <= FILL;
      countReg <= '0;
    end else if (clk_en) begin
      stateReg <= stateNext;
      countReg <= countNext;
    end
  end

  // Next-state and handshake outputs. The registers only load when clk_en is
  // high, so clk_en appears here solely to gate the REQ/ACK outputs.
  always_comb begin
    stateNext  = stateReg;
    countNext  = countReg;
    bufLoad    = 1'b0;
    bufClear   = 1'b0;
    bufLoadIdx = countReg;
    InputACK   = 1'b0;
    OutputREQ  = 1'b0;
    case (stateReg)
      FILL: begin
        InputACK = clk_en;
        if (InputREQ) begin
          // A flush in the same cycle still packs the incoming word first.
          bufLoad   = 1'b1;
          countNext = countInc;
          if ((countInc == COUNTBITWIDTH'(PACKRATIO)) || FlushREQ) begin
            stateNext = HOLD;
          end
        end else if (FlushREQ && (countReg != '0)) begin
          stateNext = HOLD;
        end
      end
      HOLD: begin
        OutputREQ = clk_en;
        // Accepting only when the sink takes the current word gives the
        // zero-bubble refill: old word leaves, new word lands in slice 0.
        InputACK  = clk_en & OutputACK;
        if (OutputACK) begin
          bufClear  = 1'b1;
          stateNext = FILL;
          if (InputREQ) begin
            bufLoad    = 1'b1;
            bufLoadIdx = '0;
            countNext  = COUNTBITWIDTH'(1);
          end else begin
            countNext  = '0;
          end
        end
      end
      default: begin
        stateNext = FILL;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < PACKRATIO; gi++) begin : gSlice
      logic [NARROWBITWIDTH-1:0] sliceReg;
      logic                      sliceHit;

      assign sliceHit = bufLoad && (bufLoadIdx == COUNTBITWIDTH'(gi));

      always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
          sliceReg <= '0;
        end else if (sync_rst) begin
          sliceReg <= '0;
        end else if (clk_en) begin
          if (sliceHit) begin
            sliceReg <= InputData;
          end else if (bufClear) begin
            sliceReg <= '0;
          end
        end
      end

      assign OutputData[gi*NARROWBITWIDTH +: NARROWBITWIDTH] = sliceReg;
    end
  endgenerate

  assign OutputCount = countReg;

endmodule

// File: tb/tb_reqack_word_packer.sv
// ---------------------------------------------------------------------------
// tb_reqack_word_packer
//
// Directed bench for reqack_word_packer with NARROWBITWIDTH=16, PACKRATIO=2.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later,
// well clear of the next rising edge.
// ---------------------------------------------------------------------------
module tb_reqack_word_packer;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic        sync_rst;
  logic        InputREQ;
  logic        InputACK;
  logic [15:0] InputData;
  logic        FlushREQ;
  logic        OutputREQ;
  logic        OutputACK;
  logic [31:0] OutputData;
  logic [1:0]  OutputCount;

  int compared   = 0;
  int mismatched = 0;

  reqack_word_packer #(
    .NARROWBITWIDTH(16),
    .PACKRATIO     (2)
  ) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .clk_en     (clk_en),
    .sync_rst   (sync_rst),
    .InputREQ   (InputREQ),
    .InputACK   (InputACK),
    .InputData  (InputData),
    .FlushREQ   (FlushREQ),
    .OutputREQ  (OutputREQ),
    .OutputACK  (OutputACK),
    .OutputData (OutputData),
    .OutputCount(OutputCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) begin
      $display("check %-22s observed %08h expected %08h ok", tag, observed, expected);
    end else begin
      mismatched++;
      $error("FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Checks the full output port in one call.
  task automatic chkOut(input string tag, input logic req, input logic [31:0] data, input logic [1:0] cnt);
    chk({tag, ".req"},   32'(OutputREQ),   32'(req));
    chk({tag, ".data"},  OutputData,       data);
    chk({tag, ".count"}, 32'(OutputCount), 32'(cnt));
  endtask

  initial begin
    async_rst_n = 1'b0;
    clk_en      = 1'b1;
    sync_rst    = 1'b0;
    InputREQ    = 1'b0;
    InputData   = 16'h0000;
    FlushREQ    = 1'b0;
    OutputACK   = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    chk("reset.iack", 32'(InputACK), 32'd1);
    chkOut("reset", 1'b0, 32'h0, 2'd0);
    async_rst_n = 1'b1;
    tick();

    // ---- basic pack, sink always ready ----
    OutputACK = 1'b1;
    InputREQ  = 1'b1;
    InputData = 16'h0009;
    tick();
    InputData = 16'h000A;
    #1;
    chk("pack.iack1", 32'(InputACK), 32'd1);
    chk("pack.noreq", 32'(OutputREQ), 32'd0);
    tick();
    InputREQ = 1'b0;
    #1;
    chkOut("pack", 1'b1, 32'h000A0009, 2'd2);
    tick();
    chkOut("pack.after", 1'b0, 32'h0, 2'd0);

    // ---- backpressure: six words offered, sink stalled ----
    OutputACK = 1'b0;
    InputREQ  = 1'b1;
    InputData = 16'h0009;
    tick();
    InputData = 16'h000A;
    tick();
    InputData = 16'h000B;
    #1;
    chk("bp.iack_stall", 32'(InputACK), 32'd0);
    chkOut("bp.hold", 1'b1, 32'h000A0009, 2'd2);
    tick();
    tick();
    chk("bp.iack_stall2", 32'(InputACK), 32'd0);
    chkOut("bp.hold2", 1'b1, 32'h000A0009, 2'd2);
    OutputACK = 1'b1;
    #1;
    chk("bp.iack_release", 32'(InputACK), 32'd1);
    tick();
    InputData = 16'h000C;
    #1;
    chk("bp.fill_noreq", 32'(OutputREQ), 32'd0);
    tick();
    InputData = 16'h000D;
    #1;
    chkOut("bp.w34", 1'b1, 32'h000C000B, 2'd2);
    tick();
    InputData = 16'h000E;
    tick();
    InputREQ = 1'b0;
    #1;
    chkOut("bp.w56", 1'b1, 32'h000E000D, 2'd2);
    tick();
    chk("bp.drained", 32'(OutputREQ), 32'd0);

    // ---- flush of a partial word ----
    OutputACK = 1'b0;
    InputREQ  = 1'b1;
    InputData = 16'h1234;
    tick();
    InputREQ = 1'b0;
    FlushREQ = 1'b1;
    #1;
    chk("flush.pre", 32'(OutputREQ), 32'd0);
    tick();
    FlushREQ = 1'b0;
    #1;
    chkOut("flush", 1'b1, 32'h00001234, 2'd1);
    OutputACK = 1'b1;
    tick();
    chk("flush.taken", 32'(OutputREQ), 32'd0);
    FlushREQ = 1'b1;
    tick();
    chk("flush.empty1", 32'(OutputREQ), 32'd0);
    tick();
    chk("flush.empty2", 32'(OutputREQ), 32'd0);
    FlushREQ = 1'b0;

    // ---- flush together with an input transfer ----
    OutputACK = 1'b0;
    InputREQ  = 1'b1;
    FlushREQ  = 1'b1;
    InputData = 16'h0055;
    tick();
    InputREQ = 1'b0;
    FlushREQ = 1'b0;
    #1;
    chkOut("flushxfer", 1'b1, 32'h00000055, 2'd1);
    OutputACK = 1'b1;
    tick();
    chk("flushxfer.taken", 32'(OutputREQ), 32'd0);

    // ---- streaming: one output word every two cycles, no bubbles ----
    OutputACK = 1'b1;
    InputREQ  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      InputData = 16'(i);
      #1;
      chk($sformatf("stream%0d.iack", i), 32'(InputACK), 32'd1);
      if (i % 2 == 0) begin
        chk($sformatf("stream%0d.req", i), 32'(OutputREQ), 32'd0);
      end else if (i > 1) begin
        chkOut($sformatf("stream%0d", i), 1'b1, {16'(i - 1), 16'(i - 2)}, 2'd2);
      end
      tick();
    end
    // Word 9 now sits alone in slice 0.

    // ---- clk_en low mid-packet ----
    InputData = 16'h0010;
    clk_en    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("cken%0d.iack", i), 32'(InputACK), 32'd0);
      chk($sformatf("cken%0d.req", i), 32'(OutputREQ), 32'd0);
      tick();
    end
    clk_en = 1'b1;
    #1;
    chk("cken.resume_iack", 32'(InputACK), 32'd1);
    tick();
    InputREQ  = 1'b0;
    OutputACK = 1'b0;
    #1;
    chkOut("cken.word", 1'b1, 32'h00100009, 2'd2);
    clk_en    = 1'b0;
    OutputACK = 1'b1;
    #1;
    chk("cken.gated_req", 32'(OutputREQ), 32'd0);
    tick();
    clk_en = 1'b1;
    #1;
    chkOut("cken.held", 1'b1, 32'h00100009, 2'd2);
    tick();
    chk("cken.taken", 32'(OutputREQ), 32'd0);

    // ---- synchronous reset with clk_en low discards the partial word ----
    InputREQ  = 1'b1;
    InputData = 16'h0077;
    tick();
    InputREQ = 1'b0;
    sync_rst = 1'b1;
    clk_en   = 1'b0;
    tick();
    sync_rst = 1'b0;
    clk_en   = 1'b1;
    FlushREQ = 1'b1;
    #1;
    chkOut("srst", 1'b0, 32'h0, 2'd0);
    tick();
    chk("srst.flush_ignored", 32'(OutputREQ), 32'd0);
    FlushREQ = 1'b0;

    // ---- asynchronous reset mid-stream ----
    OutputACK = 1'b0;
    InputREQ  = 1'b1;
    InputData = 16'h0021;
    tick();
    InputData = 16'h0022;
    tick();
    InputData = 16'h0023;
    #1;
    chkOut("arst.before", 1'b1, 32'h00220021, 2'd2);
    async_rst_n = 1'b0;
    #1;
    chk("arst.iack", 32'(InputACK), 32'd1);
    chkOut("arst", 1'b0, 32'h0, 2'd0);
    tick();
    async_rst_n = 1'b1;
    InputData   = 16'h0033;
    tick();
    InputData = 16'h0044;
    tick();
    InputREQ = 1'b0;
    #1;
    chkOut("arst.next", 1'b1, 32'h00440033, 2'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
